systolic_feeder: RTL
====================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter NBITS, default 16: width of one operand element.
REQ-002 SHALL have parameter N, default 4: array dimension; N>=1.
REQ-003 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port recv_val, input, 1: upstream beat valid.
REQ-006 SHALL have port recv_rdy, output, 1: feeder can accept a beat.
REQ-007 SHALL have port recv_last, input, 1: marks the final beat of a job.
REQ-008 SHALL have port recv_x, input, N*NBITS: row operands; lane i is bits [i*NBITS +: NBITS].
REQ-009 SHALL have port recv_w, input, N*NBITS: column operands; lanes packed as recv_x.
REQ-010 SHALL have port x_out, output, N*NBITS: skewed west-edge lanes to array rows.
REQ-011 SHALL have port w_out, output, N*NBITS: skewed north-edge lanes to array columns.
REQ-012 SHALL have port pe_en, output, 1: array enable, one pulse per wavefront.
REQ-013 SHALL have port acc_clr, output, 1: one-cycle accumulator clear, active-high.
REQ-014 SHALL have port done_val, output, 1: array sums are final.
REQ-015 SHALL have port done_rdy, input, 1: consumer has taken the sums.

Function
REQ-016 SHALL implement states LOAD, FLUSH, DRAIN, DONE, CLR.
REQ-017 SHALL assert recv_rdy only in LOAD.
REQ-018 SHALL define an advance as (LOAD and recv_val) or FLUSH.
REQ-019 SHALL make lane i of x_out and w_out a shift chain of depth i+1 that shifts only on advance; stalls hold all chains.
REQ-020 SHALL shift recv_x/recv_w into the chains on LOAD advances and shift zeros in on FLUSH advances.
REQ-021 SHALL register pe_en so it equals the previous cycle's advance.
REQ-022 SHALL transition LOAD->FLUSH on an accepted beat with recv_last=1 when N>1; LOAD->DRAIN when N=1.
REQ-023 SHALL stay in FLUSH for exactly 2N-2 cycles, then go to DRAIN.
REQ-024 SHALL hold DRAIN for one cycle with no advance, then go to DONE.
REQ-025 SHALL assert done_val throughout DONE and go to CLR on done_val and done_rdy.
REQ-026 SHALL assert acc_clr only in CLR, for one cycle, then return to LOAD.
REQ-027 SHALL keep the flush counter width at clog2(2N-1) and never let it wrap.
REQ-028 SHALL ignore recv_val outside LOAD.
REQ-029 SHALL treat a beat with recv_last=1 as a one-beat job when it is also the first beat.

Reset
REQ-030 SHALL, with rst_n=0 at a clock edge, go to LOAD, clear every chain stage to 0, drive pe_en=0, acc_clr=0, done_val=0, and drive recv_rdy=1 from the first cycle after release.
REQ-031 SHALL abandon the job when reset occurs mid-job in any state, with no done_val or acc_clr.

Structure
REQ-032 SHALL place the state enum in shared package systolic_pkg.
REQ-033 SHALL build each lane from sub-module systolic_skew_line (parameters NBITS and DEPTH; enable; synchronous active-low clear), instantiated 2N times.

Verification
REQ-034 SHALL cover, for reset (N=4): rst_n=0 for 2 cycles -> all outputs 0; recv_rdy=1 after release.
REQ-035 SHALL cover a single beat: x lanes 1,2,3,4 and w lanes 5,6,7,8 with last=1 accepted at cycle 0 ->
- pe_en high at cycles 1-7;
- x_out lane i=i+1 at cycle i+1, then 0;
- DRAIN at cycle 7; done_val at cycle 8.
REQ-036 SHALL cover stalls: 3 beats with recv_val low for 2 cycles between beats -> pe_en low during the gaps, x_out/w_out unchanged, and done_val 8 cycles after the third beat.
REQ-037 SHALL cover backpressure: done_rdy low for 5 cycles -> done_val held and recv_rdy=0; on done_rdy=1, acc_clr=1 for exactly the next cycle, then recv_rdy=1.
REQ-038 SHALL cover reset mid-FLUSH -> the next cycle shows LOAD, zeroed lanes, and no done_val.
REQ-039 SHALL cover an end-to-end case: a feeder driving a 4x4 PE array (DBITS=8) with random 4x4 fixed-point matrices -> every PE sum matches the golden matrix product at done_val.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types for the systolic-array operand feeder.
package systolic_pkg;

  typedef enum logic [2:0] {
    StLoad,
    StFlush,
    StDrain,
    StDone,
    StClr
  } feeder_state_e;

  // Counter width for 2N-2 flush cycles; at least one bit so N=1 still elaborates.
  function automatic int unsigned flush_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(2 * n - 1) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// One skewed operand lane: a DEPTH-stage shift chain that moves only when enabled.
module systolic_skew_line #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             en_i,
  input  logic [NBITS-1:0] d_i,
  output logic [NBITS-1:0] q_o
);

  logic [NBITS-1:0] stage_q [DEPTH];
  logic [NBITS-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d_i;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else if (en_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews row/column operand beats into an NxN systolic array and sequences
// flush, drain, result handoff and accumulator clear.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned NBITS = 16,
  parameter int unsigned N     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic             recv_last,
  input  logic [N*NBITS-1:0] recv_x,
  input  logic [N*NBITS-1:0] recv_w,
  output logic [N*NBITS-1:0] x_out,
  output logic [N*NBITS-1:0] w_out,
  output logic             pe_en,
  output logic             acc_clr,
  output logic             done_val,
  input  logic             done_rdy
);

  localparam int unsigned CntW       = flush_cnt_w(N);
  localparam int unsigned FlushLastI = (N > 1) ? 2 * N - 3 : 0;
  localparam logic [CntW-1:0] FlushLast = CntW'(FlushLastI);

  feeder_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rdy_q;
  logic            pe_en_q;
  logic            done_q;
  logic            clr_q;
  logic            advance;
  logic            loading;

  // rdy_q is only ever set together with entry to StLoad, so it qualifies the
  // handshake and also masks the single post-reset cycle before it rises.
  assign loading = (state_q == StLoad) && rdy_q;
  assign advance = (loading && recv_val) || (state_q == StFlush);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        cnt_d = '0;
        if (loading && recv_val && recv_last) begin
          state_d = (N > 1) ? StFlush : StDrain;
        end
      end
      StFlush: begin
        if (cnt_q == FlushLast) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        if (done_rdy) begin
          state_d = StClr;
        end
      end
      StClr:   state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      pe_en_q <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == StLoad);
      pe_en_q <= advance;
      done_q  <= (state_d == StDone);
      clr_q   <= (state_d == StClr);
    end
  end

  assign recv_rdy = rdy_q;
  assign pe_en    = pe_en_q;
  assign done_val = done_q;
  assign acc_clr  = clr_q;

  // Lane i is delayed i+1 advances; flush advances push zeros behind the job.
  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    logic [NBITS-1:0] x_in;
    logic [NBITS-1:0] w_in;

    assign x_in = (state_q == StLoad) ? recv_x[i*NBITS +: NBITS] : '0;
    assign w_in = (state_q == StLoad) ? recv_w[i*NBITS +: NBITS] : '0;

    systolic_skew_line #(
      .NBITS(NBITS),
      .DEPTH(i + 1)
    ) u_x_line (
      .clk_i (clk),
      .clr_ni(rst_n),
      .en_i  (advance),
      .d_i   (x_in),
      .q_o   (x_out[i*NBITS +: NBITS])
    );

    systolic_skew_line #(
      .NBITS(NBITS),
      .DEPTH(i + 1)
    ) u_w_line (
      .clk_i (clk),
      .clr_ni(rst_n),
      .en_i  (advance),
      .d_i   (w_in),
      .q_o   (w_out[i*NBITS +: NBITS])
    );
  end

endmodule
